// File: rtl/rv_div_pkg.sv
// Shared types and encodings for the RV32M iterative divide unit.
package rv_div_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } div_state_e;

    // op[0] selects unsigned, op[1] selects remainder
    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_CALC = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/rv_div_cla_sub.sv
// Combinational W-bit subtractor a - b = a + ~b + 1, built from rippled
// 4-bit carry-lookahead groups; borrow is the inverted carry out.
module cla_sub_nbit #(
    parameter int W = 33
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         borrow
);
    localparam int NG = (W + 3) / 4;
    localparam int WP = 4 * NG;

    logic [WP-1:0] w_a;
    logic [WP-1:0] w_b;
    logic [3:0]    w_g;
    logic [3:0]    w_p;
    logic [4:0]    w_cc;
    logic          w_c;
    logic [W-1:0]  w_s;

    // Zero-extend both operands to whole groups; inverted pad bits of b become ones.
    always_comb begin
        w_a        = '0;
        w_a[W-1:0] = a;
        w_b        = '1;
        w_b[W-1:0] = ~b;
    end

    // Group-level lookahead carries rippled between groups, carry-in of one for the +1.
    always_comb begin
        w_c  = 1'b1;
        w_s  = '0;
        w_g  = 4'b0000;
        w_p  = 4'b0000;
        w_cc = 5'b00000;
        for (int k = 0; k < NG; k++) begin
            w_g     = w_a[4*k +: 4] & w_b[4*k +: 4];
            w_p     = w_a[4*k +: 4] ^ w_b[4*k +: 4];
            w_cc[0] = w_c;
            w_cc[1] = w_g[0] | (w_p[0] & w_c);
            w_cc[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c);
            w_cc[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                    | (w_p[2] & w_p[1] & w_p[0] & w_c);
            w_cc[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                    | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                    | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c);
            for (int j = 0; j < 4; j++) begin
                if (4*k + j < W) begin
                    w_s[4*k + j] = w_p[j] ^ w_cc[j];
                end else begin
                    w_s = w_s;
                end
            end
            w_c = w_cc[4];
        end
    end

    assign diff   = w_s;
    assign borrow = ~w_c;

endmodule

// File: rtl/rv_div_unit.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit: restoring division, one quotient
// bit per cycle, with valid/ready handshakes on request and response.
module rv_div_unit
    import rv_div_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_op,
    input  logic [XLEN-1:0] in_dividend,
    input  logic [XLEN-1:0] in_divisor,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result
);
    localparam logic [CNT_W-1:0] C_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] C_XLEN = CNT_W'(XLEN);
    localparam logic [XLEN-1:0]  C_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] neg(input logic [XLEN-1:0] x);
        return ~x + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

    logic [1:0]      r_state;
    logic [1:0]      r_op;
    logic            r_neg_quo;
    logic            r_neg_rem;
    logic [XLEN-1:0] r_divisor;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quo;
    logic [CNT_W-1:0] r_cnt;
    logic            r_out_valid;
    logic [XLEN-1:0] r_out_result;

    logic            w_dvd_neg;
    logic            w_dvs_neg;
    logic [XLEN-1:0] w_dvd_abs;
    logic [XLEN-1:0] w_dvs_abs;
    logic [XLEN:0]   w_partial;
    logic [XLEN:0]   w_diff;
    logic            w_borrow;
    logic [XLEN-1:0] w_rem_next;
    logic [XLEN-1:0] w_quo_next;
    logic [XLEN-1:0] w_quo_fix;
    logic [XLEN-1:0] w_rem_fix;

    assign w_dvd_neg = ~in_op[0] & in_dividend[XLEN-1];
    assign w_dvs_neg = ~in_op[0] & in_divisor[XLEN-1];
    assign w_dvd_abs = w_dvd_neg ? neg(in_dividend) : in_dividend;
    assign w_dvs_abs = w_dvs_neg ? neg(in_divisor) : in_divisor;

    // Dividend bits enter the partial remainder from the top of the quotient register.
    assign w_partial = {r_rem, r_quo[XLEN-1]};

    cla_sub_nbit #(.W(XLEN + 1)) u_sub (
        .a      (w_partial),
        .b      ({1'b0, r_divisor}),
        .diff   (w_diff),
        .borrow (w_borrow)
    );

    assign w_rem_next = w_borrow ? w_partial[XLEN-1:0] : w_diff[XLEN-1:0];
    assign w_quo_next = {r_quo[XLEN-2:0], ~w_borrow};
    assign w_quo_fix  = r_neg_quo ? neg(w_quo_next) : w_quo_next;
    assign w_rem_fix  = r_neg_rem ? neg(w_rem_next) : w_rem_next;

    assign in_ready   = (r_state == ST_IDLE);
    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;

    // Control FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_op         <= 2'b00;
            r_neg_quo    <= 1'b0;
            r_neg_rem    <= 1'b0;
            r_divisor    <= '0;
            r_rem        <= '0;
            r_quo        <= '0;
            r_cnt        <= '0;
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid && !kill) begin
                        r_op      <= in_op;
                        r_neg_quo <= w_dvd_neg ^ w_dvs_neg;
                        r_neg_rem <= w_dvd_neg;
                        if (in_divisor == '0) begin
                            r_state      <= ST_DONE;
                            r_out_valid  <= 1'b1;
                            r_out_result <= in_op[1] ? in_dividend : '1;
                        end else if (!in_op[0] && in_dividend == C_MIN && in_divisor == '1) begin
                            r_state      <= ST_DONE;
                            r_out_valid  <= 1'b1;
                            r_out_result <= in_op[1] ? '0 : in_dividend;
                        end else begin
                            r_state   <= ST_CALC;
                            r_cnt     <= C_XLEN;
                            r_rem     <= '0;
                            r_quo     <= w_dvd_abs;
                            r_divisor <= w_dvs_abs;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    if (kill) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_rem <= w_rem_next;
                        r_quo <= w_quo_next;
                        r_cnt <= r_cnt - C_ONE;
                        if (r_cnt == C_ONE) begin
                            r_state      <= ST_DONE;
                            r_out_valid  <= 1'b1;
                            r_out_result <= r_op[1] ? w_rem_fix : w_quo_fix;
                        end else begin
                            r_state <= ST_CALC;
                        end
                    end
                end
                ST_DONE: begin
                    if (kill || out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                    end else begin
                        r_state <= ST_DONE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv_div_unit.sv
// Self-checking bench for rv_div_unit: vector table plus handshake, kill and reset sequences.
module tb_rv_div_unit;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      in_op;
    logic [XLEN-1:0] in_dividend;
    logic [XLEN-1:0] in_divisor;
    logic            kill;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;

    always #5 clk = ~clk;

    rv_div_unit #(.XLEN(XLEN)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_dividend (in_dividend),
        .in_divisor  (in_divisor),
        .kill        (kill),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        int          lat;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[16];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0)
            return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return op[1] ? 32'd0 : a;
        case (op)
            2'b00:   return $signed(a) / $signed(b);
            2'b01:   return a / b;
            2'b10:   return $signed(a) % $signed(b);
            default: return a % b;
        endcase
    endfunction

    function automatic int model_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] res, input int lat);
        exp_t e;
        int   cyc;
        @(negedge clk);
        chk({name, " in_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid    = 1'b1;
        in_op       = op;
        in_dividend = a;
        in_divisor  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        e.res = res;
        e.lat = lat;
        sb.push_back(e);
        cyc = 1;
        while (!out_valid && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        e = sb.pop_front();
        chk({name, " latency"}, cyc, e.lat);
        chk({name, " result"}, out_result, e.res);
        @(posedge clk);
        #1;
        chk({name, " released"}, {30'd0, in_ready, out_valid}, 32'd2);
    endtask

    initial begin
        logic [31:0] held;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [1:0]  rop;
        int          seen;

        vecs[0]  = '{2'b01, 32'd100,        32'd7,          32'd14,         33};
        vecs[1]  = '{2'b11, 32'd100,        32'd7,          32'd2,          33};
        vecs[2]  = '{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  33};
        vecs[3]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  33};
        vecs[4]  = '{2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1,          33};
        vecs[5]  = '{2'b00, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  1};
        vecs[6]  = '{2'b11, 32'h1234_5678,  32'd0,          32'h1234_5678,  1};
        vecs[7]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
        vecs[8]  = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
        vecs[9]  = '{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          33};
        vecs[10] = '{2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  33};
        vecs[11] = '{2'b00, 32'hFFFF_FFF8,  32'hFFFF_FFFD,  32'd2,          33};
        vecs[12] = '{2'b10, 32'hFFFF_FFF8,  32'hFFFF_FFFD,  32'hFFFF_FFFE,  33};
        vecs[13] = '{2'b00, 32'h8000_0000,  32'd1,          32'h8000_0000,  33};
        vecs[14] = '{2'b01, 32'd5,          32'd7,          32'd0,          33};
        vecs[15] = '{2'b11, 32'hDEAD_BEEF,  32'h0001_0000,  32'h0000_BEEF,  33};

        rst_n = 1'b0; in_valid = 1'b0; in_op = 2'b00; in_dividend = '0;
        in_divisor = '0; kill = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset out_result", out_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat);

        for (int i = 0; i < 8; i++) begin
            rop = 2'($urandom_range(3, 0));
            ra  = $urandom;
            rb  = (i == 3) ? 32'd0 : ($urandom >> $urandom_range(31, 0));
            run_op($sformatf("rnd%0d", i), rop, ra, rb, model_res(rop, ra, rb), model_lat(rop, ra, rb));
        end

        // Result held while the consumer stalls.
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_op = 2'b01; in_dividend = 32'd100; in_divisor = 32'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        seen = 0;
        while (!out_valid && seen < 100) begin
            @(posedge clk);
            #1;
            seen++;
        end
        chk("hold first", out_result, 32'd14);
        held = out_result;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("hold valid", {31'd0, out_valid}, 32'd1);
            chk("hold result", out_result, held);
            chk("hold in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("hold release in_ready", {31'd0, in_ready}, 32'd1);
        chk("hold release out_valid", {31'd0, out_valid}, 32'd0);

        // kill in CALC aborts the operation.
        @(negedge clk);
        in_valid = 1'b1; in_op = 2'b01; in_dividend = 32'd1000; in_divisor = 32'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        chk("kill in_ready", {31'd0, in_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) seen++;
            @(posedge clk);
            #1;
        end
        chk("kill no out_valid", seen, 32'd0);
        run_op("after kill", 2'b01, 32'd9, 32'd3, 32'd3, 33);

        // kill in IDLE blocks acceptance.
        @(negedge clk);
        in_valid = 1'b1; kill = 1'b1; in_op = 2'b00; in_dividend = 32'd5; in_divisor = 32'd0;
        @(posedge clk);
        #1;
        in_valid = 1'b0; kill = 1'b0;
        chk("idle kill in_ready", {31'd0, in_ready}, 32'd1);
        chk("idle kill out_valid", {31'd0, out_valid}, 32'd0);

        // Reset mid-CALC.
        @(negedge clk);
        in_valid = 1'b1; in_op = 2'b00; in_dividend = 32'd77; in_divisor = 32'd5;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midreset in_ready", {31'd0, in_ready}, 32'd1);
        chk("midreset out_valid", {31'd0, out_valid}, 32'd0);
        chk("midreset out_result", out_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("after reset", 2'b10, 32'd77, 32'd5, 32'd2, 33);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rv_div_unit.md
Name: rv_div_unit

Overview:
- Iterative RV32M divide/remainder unit for the execute stage; the inverse of the team's carry-lookahead adder datapath.
- Performs restoring shift-subtract division, one quotient bit per cycle, with a CLA-based subtractor.
- Covers DIV, DIVU, REM and REMU with full RISC-V special-case semantics.
- Connects to the pipeline through valid/ready handshakes on both its request and response sides.

Parameters:
- XLEN, 32, operand and result width in bits; must be a multiple of 4.
- CNT_W, $clog2(XLEN)+1, width of the iteration counter.

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request; high only in IDLE.
- in_op  in  2  00=DIV, 01=DIVU, 10=REM, 11=REMU.
- in_dividend  in  XLEN  rs1.
- in_divisor  in  XLEN  rs2.
- kill  in  1  pipeline flush; aborts any in-flight operation.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts the result.
- out_result  out  XLEN  quotient or remainder, selected by the captured op.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE; in_ready=1; out_valid=0; out_result=0.
  - Counter, remainder and quotient registers are cleared.
  - Reset wins over every other input.
- States: IDLE, CALC, DONE.
- Accept: in_valid && in_ready at edge T.
  - Capture op, sign flags and magnitudes. Signed ops take the two's-complement absolute value when the operand MSB is set; unsigned ops take the operand as is.
  - Special cases go IDLE->DONE, with out_valid at T+1:
    - Divisor==0: quotient = all ones; remainder = dividend.
    - Signed overflow (dividend = 1<<(XLEN-1), divisor = all ones, signed op): quotient = dividend; remainder = 0.
  - Otherwise IDLE->CALC with counter=XLEN.
- CALC, one iteration per cycle:
  - Form the partial remainder as {rem[XLEN-1:0], quo[XLEN-1]} in XLEN+1 bits.
  - Compute diff = partial remainder - {1'b0, divisor} with the subtractor.
  - If no borrow: rem = diff and the new quotient LSB = 1. Else: rem = the partial remainder and the LSB = 0.
  - quo shifts left by one each iteration; the counter decrements.
- On the iteration where the counter reaches 1, apply sign correction and go to DONE:
  - Quotient is negated if the signs differ (signed ops only).
  - Remainder is negated if the dividend was negative (signed ops only).
  - out_result is registered from the corrected value per op; out_valid=1 from T+XLEN+1.
- DONE:
  - out_valid=1 and out_result stable until out_valid && out_ready.
  - Then IDLE on the next edge, with in_ready=1 one cycle after the handshake.
  - No same-cycle re-accept.
- Inputs on in_* are ignored outside IDLE; in_ready=0 in CALC and DONE.
- kill:
  - From CALC or DONE: IDLE on the next edge; out_valid drops; the result is discarded.
  - Asserted in IDLE together with in_valid: the request is not accepted.
  - kill has priority over out_ready.
- Latency: XLEN+1 cycles normal, 1 cycle special; throughput is one op per XLEN+2 cycles minimum.
- Widths: the subtractor is XLEN+1 bits. Negation is ~x+1 modulo 2^XLEN, so the most negative value maps to itself.

Decomposition:
- Package rv_div_pkg:
  - div_op_e enum (DIV, DIVU, REM, REMU).
  - div_state_e enum (IDLE, CALC, DONE).
  - Localparams OP_DIV..OP_REMU.
- Sub-module cla_sub_nbit (parameter W), combinational:
  - diff = a + ~b + 1, built as a ripple of 4-bit lookahead groups.
  - Outputs diff[W-1:0] and borrow = ~carry_out.
  - Instantiated once with W=XLEN+1.

Test Plan:
- DIVU 100/7, out_ready=1 -> out_valid at accept+33, out_result=14; REMU same operands -> 2.
- DIV -7/2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); REM 7/-2 -> 1.
- DIV 0x12345678/0 -> 0xFFFFFFFF at accept+1; REMU 0x12345678/0 -> 0x12345678.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at accept+1; REM same operands -> 0.
- Hold out_ready=0 for 5 cycles after out_valid -> out_valid and result stable; in_ready=0 throughout. out_ready=1 -> in_ready=1 on the following cycle.
- kill at CALC cycle 10 -> IDLE next edge, out_valid never rises, next DIVU 9/3 returns 3. rst_n=0 mid-CALC -> all outputs at reset values on the next edge.
